// File: rtl/alu_operand_controller.sv
// alu_operand_controller
// Sequences one ALU command at a time. A command either loads an
// immediate value into register A or B, or applies an ALU function to A/B
// and writes the result back into A or B. The A/B operands and the
// function code go to an external combinational ALU. The result and the
// flags come back from that ALU.
//
// Optional feature: define ALU_CTRL_BACK2BACK_EN to accept a new command
// while in DONE. This gives one command every 2 cycles instead of every 3.
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high. cmd_ready depends only on the current state and
// never on cmd_valid. While cmd_ready is low, cmd_* inputs are ignored. A
// command whose cmd_valid is held high is taken as soon as cmd_ready
// returns high.
module alu_operand_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_op,
    input  logic       cmd_dst,
    input  logic       cmd_load,
    input  logic [7:0] cmd_imm,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [3:0] alu_f,
    input  logic [7:0] alu_c,
    input  logic [1:0] alu_flags,
    output logic       carry,
    output logic       zero,
    output logic       done,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Function codes above this value are NOPs when load is 0.
    localparam logic [3:0] LAST_LEGAL_OP = 4'b1001;

    state_t     state_q;
    state_t     state_d;
    logic       ready_int;
    logic       accept;
    logic       dst_q;
    logic       load_q;
    logic [7:0] imm_q;
    logic [7:0] a_q;
    logic [7:0] b_q;
    logic [3:0] f_q;
    logic       carry_q;
    logic       zero_q;
    logic       op_legal;
    logic       reg_wr_en;
    logic       flag_wr_en;
    logic [7:0] reg_wr_data;

    // Next-state and ready decode. A command is taken only in IDLE, and
    // also in DONE when back-to-back mode is built in.
    always_comb begin
        state_d   = state_q;
        ready_int = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready_int = 1'b1;
                if (cmd_valid) begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
`ifdef ALU_CTRL_BACK2BACK_EN
                ready_int = 1'b1;
                if (cmd_valid) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_IDLE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Write-back decode. This is active only in EXEC, so the write lands on
    // the EXEC->DONE edge. A load writes the captured immediate and leaves
    // the flags alone. A legal ALU op writes both the result and the flags.
    // An illegal op writes nothing.
    always_comb begin
        accept      = cmd_valid && ready_int;
        op_legal    = (f_q <= LAST_LEGAL_OP);
        reg_wr_en   = (state_q == ST_EXEC) && (load_q || op_legal);
        flag_wr_en  = (state_q == ST_EXEC) && !load_q && op_legal;
        reg_wr_data = load_q ? imm_q : alu_c;
    end

    // State, command capture, operand registers and flags. Reset wins over
    // any handshake and drops a command that is in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            dst_q   <= 1'b0;
            load_q  <= 1'b0;
            imm_q   <= 8'h00;
            f_q     <= 4'h0;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                f_q    <= cmd_op;
                dst_q  <= cmd_dst;
                load_q <= cmd_load;
                imm_q  <= cmd_imm;
            end
            // Only the selected register is written. The ALU result was
            // computed from the pre-write values of both registers.
            if (reg_wr_en) begin
                if (dst_q) begin
                    b_q <= reg_wr_data;
                end else begin
                    a_q <= reg_wr_data;
                end
            end
            if (flag_wr_en) begin
                carry_q <= alu_flags[1];
                zero_q  <= alu_flags[0];
            end
        end
    end

    // The outputs are taken straight from the flops. done is decoded from
    // the state register alone, so it is glitch-free.
    always_comb begin
        cmd_ready = ready_int;
        alu_a     = a_q;
        alu_b     = b_q;
        alu_f     = f_q;
        carry     = carry_q;
        zero      = zero_q;
        done      = (state_q == ST_DONE);
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_alu_operand_controller.sv
// tb_alu_operand_controller
// Scoreboard bench. An environment ALU drives alu_c/alu_flags. A
// reference model updates A/B/flags at command acceptance and pushes the
// expected post-command view. A monitor pops one entry on every done pulse.
module tb_alu_operand_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic       cmd_dst;
    logic       cmd_load;
    logic [7:0] cmd_imm;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_f;
    logic [7:0] alu_c;
    logic [1:0] alu_flags;
    logic       carry;
    logic       zero;
    logic       done;
    logic [1:0] dbg_state;

`ifdef ALU_CTRL_BACK2BACK_EN
    localparam int GAP = 2;
`else
    localparam int GAP = 3;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    int cycle  = 0;

    // Expected view per command: {f, a, b, carry, zero}.
    logic [21:0] exp_q[$];
    int          exp_cyc[$];

    // Reference register and flag state.
    logic [7:0] m_a, m_b;
    logic       m_c, m_z;

    // ---------------- clock / reset-free cycle count ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    alu_operand_controller dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_dst   (cmd_dst),
        .cmd_load  (cmd_load),
        .cmd_imm   (cmd_imm),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_f     (alu_f),
        .alu_c     (alu_c),
        .alu_flags (alu_flags),
        .carry     (carry),
        .zero      (zero),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // Environment ALU. Returns {carry, zero, result}.
    function automatic logic [9:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] w;
        case (op)
            4'd0: w = {1'b0, a};
            4'd1: w = {1'b0, b};
            4'd2: w = {1'b0, a} + 9'd1;
            4'd3: w = {1'b0, a} - 9'd1;
            4'd4: w = {1'b0, a} + {1'b0, b};
            4'd5: w = {1'b0, a} - {1'b0, b};
            4'd6: w = {1'b0, a & b};
            4'd7: w = {1'b0, a | b};
            4'd8: w = {1'b0, a ^ b};
            4'd9: w = {1'b0, ~a};
            default: w = 9'd0;
        endcase
        return {w[8], (w[7:0] == 8'd0), w[7:0]};
    endfunction

    assign {alu_flags, alu_c} = alu_fn(alu_f, alu_a, alu_b);

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic model_reset();
        m_a = 8'h00;
        m_b = 8'h00;
        m_c = 1'b0;
        m_z = 1'b0;
        exp_q.delete();
        exp_cyc.delete();
    endtask

    task automatic model_accept(input logic [3:0] op, input logic dst, input logic load, input logic [7:0] imm);
        logic [9:0] r;
        if (load) begin
            if (dst) m_b = imm; else m_a = imm;
        end else if (op <= 4'd9) begin
            r = alu_fn(op, m_a, m_b);
            if (dst) m_b = r[7:0]; else m_a = r[7:0];
            m_c = r[9];
            m_z = r[8];
        end
        exp_q.push_back({op, m_a, m_b, m_c, m_z});
        exp_cyc.push_back(cycle + 2);
    endtask

    // ---------------- driver ----------------
    task automatic send(input logic [3:0] op, input logic dst, input logic load,
                        input logic [7:0] imm, output int acc_cyc);
        int w;
        cmd_op    = op;
        cmd_dst   = dst;
        cmd_load  = load;
        cmd_imm   = imm;
        cmd_valid = 1'b1;
        w = 0;
        acc_cyc = -1;
        while (!cmd_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!cmd_ready) begin
            check("ready_timeout", {31'd0, cmd_ready}, 32'd1);
            cmd_valid = 1'b0;
        end else begin
            model_accept(op, dst, load, imm);
            acc_cyc = cycle;
            @(negedge clk);
            cmd_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("drain_timeout", exp_q.size(), 32'd0);
        @(negedge clk);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [21:0] e;
        int          c;
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                check("spurious_done", {31'd0, done}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                c = exp_cyc.pop_front();
                check("alu_f", {28'd0, alu_f}, {28'd0, e[21:18]});
                check("alu_a", {24'd0, alu_a}, {24'd0, e[17:10]});
                check("alu_b", {24'd0, alu_b}, {24'd0, e[9:2]});
                check("carry", {31'd0, carry}, {31'd0, e[1]});
                check("zero",  {31'd0, zero},  {31'd0, e[0]});
                check("done_latency", cycle, c);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int c1, c2, ca;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 4'h0;
        cmd_dst   = 1'b0;
        cmd_load  = 1'b0;
        cmd_imm   = 8'h00;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;

        check("rst_a",     {24'd0, alu_a}, 32'h00);
        check("rst_b",     {24'd0, alu_b}, 32'h00);
        check("rst_f",     {28'd0, alu_f}, 32'h0);
        check("rst_carry", {31'd0, carry}, 32'd0);
        check("rst_zero",  {31'd0, zero},  32'd0);
        check("rst_done",  {31'd0, done},  32'd0);
        check("rst_ready", {31'd0, cmd_ready}, 32'd1);

        // Immediate loads; flags stay at 0.
        send(4'h0, 1'b0, 1'b1, 8'h05, ca);
        send(4'h0, 1'b1, 1'b1, 8'h03, ca);
        drain();
        check("load_a", {24'd0, alu_a}, 32'h05);
        check("load_b", {24'd0, alu_b}, 32'h03);
        check("load_carry", {31'd0, carry}, 32'd0);

        // Add with carry out: 0xF0 + 0x20.
        send(4'h0, 1'b0, 1'b1, 8'hF0, ca);
        send(4'h0, 1'b1, 1'b1, 8'h20, ca);
        send(4'h4, 1'b0, 1'b0, 8'h00, ca);
        drain();
        check("add_a",     {24'd0, alu_a}, 32'h10);
        check("add_carry", {31'd0, carry}, 32'd1);
        check("add_zero",  {31'd0, zero},  32'd0);

        // Subtract into B to get zero; A untouched.
        send(4'h0, 1'b0, 1'b1, 8'h03, ca);
        send(4'h0, 1'b1, 1'b1, 8'h03, ca);
        send(4'h5, 1'b1, 1'b0, 8'h00, ca);
        drain();
        check("sub_b",     {24'd0, alu_b}, 32'h00);
        check("sub_a",     {24'd0, alu_a}, 32'h03);
        check("sub_carry", {31'd0, carry}, 32'd0);
        check("sub_zero",  {31'd0, zero},  32'd1);

        // Illegal op is a NOP that still completes.
        send(4'hC, 1'b0, 1'b0, 8'h55, ca);
        drain();
        check("nop_a",    {24'd0, alu_a}, 32'h03);
        check("nop_b",    {24'd0, alu_b}, 32'h00);
        check("nop_zero", {31'd0, zero},  32'd1);

        // Reset during EXEC drops the command.
        send(4'h0, 1'b0, 1'b1, 8'h7F, ca);
        drain();
        send(4'h2, 1'b0, 1'b0, 8'h00, ca);
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        check("abort_a",     {24'd0, alu_a}, 32'h00);
        check("abort_f",     {28'd0, alu_f}, 32'h0);
        check("abort_done",  {31'd0, done},  32'd0);
        check("abort_ready", {31'd0, cmd_ready}, 32'd1);
        repeat (4) @(negedge clk);

        // Reset wins over a simultaneous handshake.
        cmd_valid = 1'b1;
        cmd_load  = 1'b1;
        cmd_dst   = 1'b0;
        cmd_imm   = 8'hAA;
        reset     = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        cmd_valid = 1'b0;
        check("rstwin_a",     {24'd0, alu_a}, 32'h00);
        check("rstwin_ready", {31'd0, cmd_ready}, 32'd1);
        repeat (4) @(negedge clk);

        // Held valid across two commands: handshake spacing.
        send(4'h0, 1'b0, 1'b1, 8'h11, c1);
        send(4'h0, 1'b1, 1'b1, 8'h22, c2);
        check("handshake_gap", c2 - c1, GAP);
        drain();

        // Randomized traffic.
        for (int i = 0; i < 60; i++) begin
            send(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0), 8'($urandom_range(0, 255)), ca);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();
        check("final_a", {24'd0, alu_a}, {24'd0, m_a});
        check("final_b", {24'd0, alu_b}, {24'd0, m_b});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish by time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
